// File: rtl/bram_stream_loader_pkg.sv
// rtl/bram_stream_loader_pkg.sv - shared geometry and FSM state type for the BRAM table loader
package bram_stream_loader_pkg;

    localparam int DATA_W        = 8;
    localparam int ADDR_W        = 12;
    localparam int DEPTH_DEFAULT = 576;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DRAIN,
        VERIFY,
        DONE
    } state_t;

endpackage

// File: rtl/bram_stream_loader_if.sv
// rtl/bram_stream_loader_if.sv - byte stream handshake between a source and the loader
interface bram_stream_loader_if #(
    parameter int DATA_W = bram_stream_loader_pkg::DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;

    // Byte source side
    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    // Loader side
    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/bram_checksum_acc.sv
// rtl/bram_checksum_acc.sv - running modular sum and xor of a byte sequence
module bram_checksum_acc
    import bram_stream_loader_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] sum,
    output logic [W-1:0] xr
);

    // Clear wins over accumulate so a new load never inherits a stale byte
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
            xr  <= '0;
        end else if (en) begin
            sum <= sum + data;
            xr  <= xr ^ data;
        end
    end

endmodule

// File: rtl/bram_stream_loader.sv
// rtl/bram_stream_loader.sv - writes a byte stream into BRAM port A, then reads it back to verify
module bram_stream_loader #(
    parameter int DATA_W = bram_stream_loader_pkg::DATA_W,
    parameter int ADDR_W = bram_stream_loader_pkg::ADDR_W,
    parameter int DEPTH  = bram_stream_loader_pkg::DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bram_stream_loader_if.slave  strm,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [DATA_W-1:0]    bram_din,
    output logic                 bram_we,
    input  logic [DATA_W-1:0]    bram_dout,
    output logic                 busy,
    output logic                 done,
    output logic                 ok,
    output logic                 overflow,
    output logic [ADDR_W:0]      word_count
);

    import bram_stream_loader_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   WC_ONE   = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              in_ready_q;
    logic              rd_issue;     // a read address is on the bus this cycle
    logic              rd_valid;     // bram_dout carries a verify word this cycle
    logic              rd_last;      // that word is the final one
    logic              cmp_pending;  // verify accumulator holds every word

    logic [DATA_W-1:0] w_sum, w_xr, v_sum, v_xr;

    logic              beat;
    logic              wr_fire;
    logic              start_ok;
    logic              at_last;
    logic              match;
    logic [ADDR_W:0]   wc_inc;
    logic [ADDR_W:0]   wc_m1;

    assign beat     = strm.in_valid && in_ready_q;
    assign wr_fire  = beat && (state == WRITE);
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign wc_inc   = word_count + WC_ONE;
    assign wc_m1    = word_count - WC_ONE;
    assign at_last  = ({1'b0, addr_q} == wc_m1);
    assign match    = (v_sum == w_sum) && (v_xr == w_xr);

    // The write lands in the acceptance cycle; otherwise the port holds its last address
    assign strm.in_ready = in_ready_q;
    assign bram_we       = wr_fire;
    assign bram_addr     = wr_fire ? word_count[ADDR_W-1:0] : addr_q;
    assign bram_din      = wr_fire ? strm.in_data : din_q;

    bram_checksum_acc #(.W(DATA_W)) u_wr_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (wr_fire),
        .data (strm.in_data),
        .sum  (w_sum),
        .xr   (w_xr)
    );

    bram_checksum_acc #(.W(DATA_W)) u_rd_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (rd_valid),
        .data (bram_dout),
        .sum  (v_sum),
        .xr   (v_xr)
    );

    // Load sequencer: write phase, overflow drain, readback verify, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ok          <= 1'b0;
            overflow    <= 1'b0;
            word_count  <= '0;
            rd_issue    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            cmp_pending <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WRITE;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        ok         <= 1'b0;
                        overflow   <= 1'b0;
                        word_count <= '0;
                    end
                end
                WRITE: begin
                    if (beat) begin
                        addr_q     <= word_count[ADDR_W-1:0];
                        din_q      <= strm.in_data;
                        word_count <= wc_inc;
                        if (strm.in_last) begin
                            state      <= VERIFY;
                            in_ready_q <= 1'b0;
                            addr_q     <= '0;
                            rd_issue   <= 1'b1;
                        end else if (wc_inc == DEPTH_W) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat) begin
                        overflow <= 1'b1;
                        if (strm.in_last) begin
                            state      <= DONE;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            ok         <= 1'b0;
                        end
                    end
                end
                VERIFY: begin
                    rd_valid    <= rd_issue;
                    rd_last     <= rd_issue && at_last;
                    cmp_pending <= rd_last;
                    if (rd_issue) begin
                        if (at_last) begin
                            rd_issue <= 1'b0;
                        end else begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                    end
                    if (cmp_pending) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ok    <= match && !overflow;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_loader.sv
// tb/tb_bram_stream_loader.sv - scoreboard bench for the BRAM stream loader
module tb_bram_stream_loader;

    localparam int DW    = 8;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic          ok;
    logic          overflow;
    logic [AW:0]   word_count;

    int errors = 0;
    int checks = 0;

    bram_stream_loader_if #(.DATA_W(DW)) strm ();

    bram_stream_loader #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .strm       (strm),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .bram_dout  (bram_dout),
        .busy       (busy),
        .done       (done),
        .ok         (ok),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // BRAM port A model, read-first, optional corruption of address 1 on readback
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            corrupt = 1'b0;
    always @(posedge clk) begin
        bram_dout <= (corrupt && bram_addr == 1) ? (mem[bram_addr] ^ 8'h04) : mem[bram_addr];
        if (bram_we) mem[bram_addr] = bram_din;
    end

    // Scoreboard: expected {addr, data} writes in order
    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] exp_w;
    always @(negedge clk) begin
        if (bram_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h din=%0h (no write expected)", bram_addr, bram_din);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bram_addr, bram_din} !== exp_w) begin
                    errors++;
                    $display("FAIL write addr/din got=%0h/%0h want=%0h/%0h",
                             bram_addr, bram_din, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    int          m_wc;
    logic [7:0]  m_sum;
    logic [7:0]  m_xor;
    int          cyc;

    task automatic do_start;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_wc  = 0;
        m_sum = 8'h00;
        m_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        strm.in_data  = d;
        strm.in_valid = 1'b1;
        strm.in_last  = last;
        if (m_wc < DEPTH) begin
            exp_q.push_back({AW'(m_wc), d});
            m_sum = m_sum + d;
            m_xor = m_xor ^ d;
        end
        m_wc++;
        @(posedge clk); #1;
        strm.in_valid = 1'b0;
        strm.in_last  = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({strm.in_ready, bram_we, busy, done, ok, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000", {strm.in_ready, bram_we, busy, done, ok, overflow});
        end
        checks++;
        if (word_count !== 0 || bram_addr !== 0 || bram_din !== 0) begin
            errors++;
            $display("FAIL reset_regs wc/addr/din got=%0d/%0h/%0h want=0/0/0", word_count, bram_addr, bram_din);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        do_start();
        checks++;
        if (strm.in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_write_state in_ready/busy got=%b/%b want=1/1", strm.in_ready, busy);
        end
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL basic_latency got=%0d want=5", cyc);
        end
        checks++;
        if (dut.u_wr_acc.sum !== m_sum || dut.u_wr_acc.xr !== m_xor || m_sum !== 8'h06 || m_xor !== 8'h00) begin
            errors++;
            $display("FAIL basic_checksum sum/xor got=%0h/%0h want=06/00", dut.u_wr_acc.sum, dut.u_wr_acc.xr);
        end
        checks++;
        if (word_count !== 3 || ok !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result wc/ok/ovf/busy got=%0d/%b/%b/%b want=3/1/0/0", word_count, ok, overflow, busy);
        end
        checks++;
        if (mem[0] !== 8'h01 || mem[1] !== 8'h02 || mem[2] !== 8'h03) begin
            errors++;
            $display("FAIL basic_mem got=%0h %0h %0h want=01 02 03", mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_gaps;
        do_start();
        send_byte(8'hA5, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        send_byte(8'h5A, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL gaps_latency got=%0d want=4", cyc);
        end
        checks++;
        if (word_count !== 2 || ok !== 1'b1 || mem[0] !== 8'hA5 || mem[1] !== 8'h5A) begin
            errors++;
            $display("FAIL gaps_result wc/ok/mem0/mem1 got=%0d/%b/%0h/%0h want=2/1/a5/5a",
                     word_count, ok, mem[0], mem[1]);
        end
    endtask

    task automatic test_exact_fill;
        do_start();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h7E, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== DEPTH + 2) begin
            errors++;
            $display("FAIL fill_latency got=%0d want=%0d", cyc, DEPTH + 2);
        end
        checks++;
        if (word_count !== DEPTH || ok !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_result wc/ok/ovf got=%0d/%b/%b want=%0d/1/0", word_count, ok, overflow, DEPTH);
        end
    endtask

    task automatic test_overflow;
        do_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h10 + 8'(i), i == 5);
            if (i == 4) begin
                checks++;
                if (busy !== 1'b1 || strm.in_ready !== 1'b1 || overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_state busy/in_ready/ovf got=%b/%b/%b want=1/1/1",
                             busy, strm.in_ready, overflow);
                end
            end
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 0) begin
            errors++;
            $display("FAIL overflow_latency got=%0d want=0", cyc);
        end
        checks++;
        if (word_count !== DEPTH || ok !== 1'b0 || overflow !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL overflow_result wc/ok/ovf/done got=%0d/%b/%b/%b want=%0d/0/1/1",
                     word_count, ok, overflow, done, DEPTH);
        end
        checks++;
        if (mem[0] !== 8'h10 || mem[1] !== 8'h11 || mem[2] !== 8'h12 || mem[3] !== 8'h13) begin
            errors++;
            $display("FAIL overflow_mem got=%0h %0h %0h %0h want=10 11 12 13", mem[0], mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_corrupt;
        corrupt = 1'b1;
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        wait_done(cyc);
        corrupt = 1'b0;
        checks++;
        if (done !== 1'b1 || ok !== 1'b0 || overflow !== 1'b0 || cyc !== 5) begin
            errors++;
            $display("FAIL corrupt_result done/ok/ovf/lat got=%b/%b/%b/%0d want=1/0/0/5", done, ok, overflow, cyc);
        end
    endtask

    task automatic test_reset_mid;
        do_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({strm.in_ready, bram_we, busy, done, ok, overflow} !== 6'b0 || word_count !== 0
            || bram_addr !== 0 || bram_din !== 0) begin
            errors++;
            $display("FAIL midreset_outputs flags=%b wc=%0d addr=%0h din=%0h want flags=000000 wc=0 addr=0 din=0",
                     {strm.in_ready, bram_we, busy, done, ok, overflow}, word_count, bram_addr, bram_din);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || strm.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_beats_start busy/in_ready got=%b/%b want=0/0", busy, strm.in_ready);
        end
        do_start();
        send_byte(8'hFF, 1'b1);
        wait_done(cyc);
        checks++;
        if (word_count !== 1 || ok !== 1'b1 || cyc !== 3) begin
            errors++;
            $display("FAIL after_reset_load wc/ok/lat got=%0d/%b/%0d want=1/1/3", word_count, ok, cyc);
        end
    endtask

    task automatic test_start_ignored;
        do_start();
        send_byte(8'h09, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h07, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || word_count !== 3 || strm.in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL verify_start busy/wc/in_ready/done got=%b/%0d/%b/%b want=1/3/0/0",
                     busy, word_count, strm.in_ready, done);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 4 || ok !== 1'b1 || word_count !== 3) begin
            errors++;
            $display("FAIL verify_start_result lat/ok/wc got=%0d/%b/%0d want=4/1/3", cyc, ok, word_count);
        end
        do_start();
        checks++;
        if (done !== 1'b0 || strm.in_ready !== 1'b1 || word_count !== 0 || ok !== 1'b0) begin
            errors++;
            $display("FAIL done_restart done/in_ready/wc/ok got=%b/%b/%0d/%b want=0/1/0/0",
                     done, strm.in_ready, word_count, ok);
        end
        send_byte(8'h77, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc !== 3 || ok !== 1'b1 || word_count !== 1) begin
            errors++;
            $display("FAIL restart_load lat/ok/wc got=%0d/%b/%0d want=3/1/1", cyc, ok, word_count);
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        strm.in_data  = '0;
        strm.in_valid = 1'b0;
        strm.in_last  = 1'b0;
        m_wc          = 0;
        m_sum         = 8'h00;
        m_xor         = 8'h00;

        test_reset();
        test_basic();
        test_gaps();
        test_exact_fill();
        test_overflow();
        test_corrupt();
        test_reset_mid();
        test_start_ignored();

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL writes_outstanding got=%0d want=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
